switch_led_ctrl: RTL and testbench

Parametrised switch-to-LED controller: N_SW active-low push-buttons are synchronised, debounced and edge-detected, then mapped onto N_LED outputs. Each LED has a run-time selectable switch mask and mode: direct, inverted, toggle or blink. It sits between the board's button pins and LED pins and replaces hard-wired switch/LED logic in all further PBL designs.

---
 rtl/switch_led_pkg.sv | 20 ++
 rtl/sw_debounce.sv | 64 ++++++
 rtl/switch_led_ctrl.sv | 110 +++++++++++
 tb/tb_switch_led_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_led_pkg.sv
// ---------------------------------------------------------------------------
// switch_led_pkg
// Shared definitions for the switch-to-LED controller.
//   MODE_*     : per-LED operating mode encodings carried on led_mode
//   cnt_width  : width of a counter that must hold the values 0..n-1
// ---------------------------------------------------------------------------
package switch_led_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // A counter that runs 0..n-1 needs $clog2(n) bits. For n == 1 that is
  // zero bits, which cannot be declared, so one bit is the floor.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// One switch channel: two-flop synchroniser, debounce counter, accepted
// level and press-edge detector.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   switch_n   : raw switch pin, active low, asynchronous to clk
//   sw_pressed : debounced level, active high
//   sw_event   : single-cycle pulse when a press is accepted
// ---------------------------------------------------------------------------
module sw_debounce
  import switch_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_n,
  output logic sw_pressed,
  output logic sw_event
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic [CW-1:0] cnt;
  logic          evt;

  // Synchroniser, debounce counter and accepted level all live in one
  // register process. db keeps the raw (active-low) polarity, so a reset
  // value of 1 means "released". The counter only runs while the
  // synchronised level disagrees with db; any agreement clears it, which is
  // what throws away short glitches. The event is raised on the same edge
  // that db falls, and only then, so releases produce no event.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      db  <= 1'b1;
      cnt <= '0;
      evt <= 1'b0;
    end else begin
      s1  <= switch_n;
      s2  <= s1;
      evt <= 1'b0;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
        evt <= db;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign sw_pressed = ~db;
  assign sw_event   = evt;

endmodule

// File: rtl/switch_led_ctrl.sv
// ---------------------------------------------------------------------------
// switch_led_ctrl
// Debounces N_SW active-low buttons and maps them onto N_LED registered LED
// outputs. Each LED selects its switches with a mask and its behaviour with
// a two-bit mode (direct, inverted, toggle, blink).
//   clk        : system clock
//   rst        : synchronous active-high reset
//   switch_n   : raw switch pins, active low
//   led_mask   : bits [i*N_SW +: N_SW] choose the switches for LED i
//   led_mode   : bits [2i +: 2] choose the mode for LED i
//   sw_pressed : debounced switch levels, active high
//   sw_event   : one-cycle press pulses
//   led        : LED drive, active high
// ---------------------------------------------------------------------------
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int N_SW            = 4,
  parameter int N_LED           = 2,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int BLINK_HALF      = 3000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SW-1:0]       switch_n,
  input  logic [N_SW*N_LED-1:0] led_mask,
  input  logic [2*N_LED-1:0]    led_mode,
  output logic [N_SW-1:0]       sw_pressed,
  output logic [N_SW-1:0]       sw_event,
  output logic [N_LED-1:0]      led
);

  localparam int BW = cnt_width(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0]    blink_cnt;
  logic             phase;
  logic [N_LED-1:0] any_sw;
  logic [N_LED-1:0] ev_sw;
  logic [N_LED-1:0] tgl;
  logic [N_LED-1:0] tgl_next;
  logic [N_LED-1:0] led_q;
  logic [N_LED-1:0] led_next;

  // One independent debounce channel per switch.
  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .switch_n  (switch_n[g]),
      .sw_pressed(sw_pressed[g]),
      .sw_event  (sw_event[g])
    );
  end

  // Free-running blink timebase shared by every LED. The phase flips each
  // time the counter wraps, giving BLINK_HALF cycles high and BLINK_HALF
  // low. Mode and mask changes deliberately never touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // LED mapping. OR-reducing the masked events means several switches
  // accepted in the same cycle still flip the toggle only once. The toggle
  // state follows its events whatever the current mode, and the toggle LED
  // shows the post-flip value so it lines up with the direct mode timing.
  always_comb begin
    any_sw   = '0;
    ev_sw    = '0;
    tgl_next = tgl;
    led_next = '0;
    for (int i = 0; i < N_LED; i++) begin
      any_sw[i]   = |(sw_pressed & led_mask[i*N_SW +: N_SW]);
      ev_sw[i]    = |(sw_event & led_mask[i*N_SW +: N_SW]);
      tgl_next[i] = tgl[i] ^ ev_sw[i];
      case (led_mode[2*i +: 2])
        MODE_DIRECT: led_next[i] = any_sw[i];
        MODE_INVERT: led_next[i] = ~any_sw[i];
        MODE_TOGGLE: led_next[i] = tgl_next[i];
        MODE_BLINK:  led_next[i] = any_sw[i] & phase;
        default:     led_next[i] = 1'b0;
      endcase
    end
  end

  // Toggle state and LED outputs are registered so that nothing at the
  // pins reaches an output without passing through a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgl   <= '0;
      led_q <= '0;
    end else begin
      tgl   <= tgl_next;
      led_q <= led_next;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_switch_led_ctrl
// Directed self-checking bench for switch_led_ctrl with short debounce and
// blink periods. Inputs change after the falling edge, outputs are sampled
// after the falling edge that follows each rising edge.
// ---------------------------------------------------------------------------
module tb_switch_led_ctrl;

  localparam int N_SW            = 4;
  localparam int N_LED           = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int BLINK_HALF      = 3;

  logic                  clk;
  logic                  rst;
  logic [N_SW-1:0]       switch_n;
  logic [N_SW*N_LED-1:0] led_mask;
  logic [2*N_LED-1:0]    led_mode;
  logic [N_SW-1:0]       sw_pressed;
  logic [N_SW-1:0]       sw_event;
  logic [N_LED-1:0]      led;

  int checks;
  int errors;

  switch_led_ctrl #(
    .N_SW           (N_SW),
    .N_LED          (N_LED),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BLINK_HALF     (BLINK_HALF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .switch_n  (switch_n),
    .led_mask  (led_mask),
    .led_mode  (led_mode),
    .sw_pressed(sw_pressed),
    .sw_event  (sw_event),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset held three cycles: LED0 direct on 1001, LED1 inverted on 0010.
  task automatic test_reset();
    switch_n = 4'b1111;
    led_mask = {4'b0010, 4'b1001};
    led_mode = {2'd1, 2'd0};
    rst      = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if ({led, sw_pressed, sw_event} !== 10'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold[%0d]: led=%b pressed=%b event=%b, expected all zero",
                 j, led, sw_pressed, sw_event);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (led !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_release: led=%b expected 10", led);
    end
  endtask

  // Press and release sw0, checking every edge of the latency window.
  task automatic test_debounce_latency();
    logic [9:0] exp_v;
    switch_n = 4'b1110;
    for (int j = 0; j <= 6; j++) begin
      step();
      exp_v = {(j == 5) ? 4'b0001 : 4'b0000,
               (j >= 5) ? 4'b0001 : 4'b0000,
               1'b1, (j >= 6)};
      checks++;
      if ({sw_event, sw_pressed, led} !== exp_v) begin
        errors++;
        $display("[TB] FAIL press_latency[%0d]: ev/pr/led=%b expected %b",
                 j, {sw_event, sw_pressed, led}, exp_v);
      end
    end
    switch_n = 4'b1111;
    for (int j = 0; j <= 6; j++) begin
      step();
      exp_v = {4'b0000,
               (j < 5) ? 4'b0001 : 4'b0000,
               1'b1, (j < 6)};
      checks++;
      if ({sw_event, sw_pressed, led} !== exp_v) begin
        errors++;
        $display("[TB] FAIL release_latency[%0d]: ev/pr/led=%b expected %b",
                 j, {sw_event, sw_pressed, led}, exp_v);
      end
    end
  endtask

  // Low pulses of 1, 3 and 4 cycles on sw3; only the last is accepted.
  task automatic test_glitch();
    int         widths[3] = '{1, 3, 4};
    logic [9:0] exp_v;
    for (int p = 0; p < 3; p++) begin
      switch_n = 4'b0111;
      for (int j = 0; j < 14; j++) begin
        step();
        if (j == widths[p] - 1) switch_n = 4'b1111;
        if (widths[p] == 4)
          exp_v = {(j == 5) ? 4'b1000 : 4'b0000,
                   (j >= 5 && j <= 8) ? 4'b1000 : 4'b0000,
                   1'b1, (j >= 6 && j <= 9)};
        else
          exp_v = {4'b0000, 4'b0000, 2'b10};
        checks++;
        if ({sw_event, sw_pressed, led} !== exp_v) begin
          errors++;
          $display("[TB] FAIL glitch_w%0d[%0d]: ev/pr/led=%b expected %b",
                   widths[p], j, {sw_event, sw_pressed, led}, exp_v);
        end
      end
    end
  endtask

  // LED0 toggles from sw0/sw1; a simultaneous press flips it only once.
  // The earlier sw0 press and accepted sw3 pulse left tgl0 back at 0.
  task automatic test_toggle();
    logic [3:0] presses[3] = '{4'b0001, 4'b0010, 4'b0011};
    logic       exp_led0[3] = '{1'b1, 1'b0, 1'b1};
    logic       prev;
    led_mask = {4'b0100, 4'b0011};
    led_mode = {2'd1, 2'd2};
    step();
    checks++;
    if (led !== 2'b10) begin
      errors++;
      $display("[TB] FAIL toggle_start: led=%b expected 10", led);
    end
    prev = 1'b0;
    for (int p = 0; p < 3; p++) begin
      switch_n = ~presses[p];
      repeat (6) step();
      checks++;
      if ({sw_event, led} !== {presses[p], 1'b1, prev}) begin
        errors++;
        $display("[TB] FAIL toggle_event[%0d]: ev/led=%b expected %b",
                 p, {sw_event, led}, {presses[p], 1'b1, prev});
      end
      step();
      checks++;
      if (led !== {1'b1, exp_led0[p]}) begin
        errors++;
        $display("[TB] FAIL toggle_flip[%0d]: led=%b expected %b",
                 p, led, {1'b1, exp_led0[p]});
      end
      switch_n = 4'b1111;
      repeat (8) step();
      checks++;
      if ({sw_pressed, led} !== {4'b0000, 1'b1, exp_led0[p]}) begin
        errors++;
        $display("[TB] FAIL toggle_hold[%0d]: pr/led=%b expected %b",
                 p, {sw_pressed, led}, {4'b0000, 1'b1, exp_led0[p]});
      end
      prev = exp_led0[p];
    end
  endtask

  // LED1 blinks while sw2 is held: three cycles high, three low.
  task automatic test_blink();
    logic s[14];
    int   rise;
    led_mode = {2'd3, 2'd2};
    switch_n = 4'b1011;
    repeat (7) step();
    for (int j = 0; j < 14; j++) begin
      step();
      s[j] = led[1];
    end
    rise = -1;
    for (int r = 1; r <= 6; r++)
      if (rise < 0 && s[r-1] == 1'b0 && s[r] == 1'b1) rise = r;
    checks++;
    if (rise < 0) begin
      errors++;
      $display("[TB] FAIL blink_rise: no rising edge of led[1] seen, expected one within 6 cycles");
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (s[rise + j] !== ((j % 6) < 3)) begin
          errors++;
          $display("[TB] FAIL blink_pattern[%0d]: led1=%b expected %b",
                   j, s[rise + j], ((j % 6) < 3));
        end
      end
    end
    switch_n = 4'b1111;
    repeat (7) step();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (led[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL blink_release[%0d]: led1=%b expected 0", j, led[1]);
      end
      step();
    end
  endtask

  // Reset while sw0 is mid-debounce and tgl0 is set; the held switch is
  // accepted again after release with exactly one event.
  task automatic test_reset_mid();
    logic [9:0] exp_v;
    int         ev_count;
    checks++;
    if (led[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre: led0=%b expected 1", led[0]);
    end
    switch_n = 4'b1110;
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if ({led, sw_pressed, sw_event} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL midrst_in_reset: led/pr/ev=%b expected all zero",
               {led, sw_pressed, sw_event});
    end
    rst      = 1'b0;
    ev_count = 0;
    for (int j = 0; j < 14; j++) begin
      step();
      if (sw_event[0]) ev_count++;
      if (j <= 7) begin
        exp_v = {(j == 5) ? 4'b0001 : 4'b0000,
                 (j >= 5) ? 4'b0001 : 4'b0000,
                 1'b0, (j >= 6)};
        checks++;
        if ({sw_event, sw_pressed, led} !== exp_v) begin
          errors++;
          $display("[TB] FAIL midrst_after[%0d]: ev/pr/led=%b expected %b",
                   j, {sw_event, sw_pressed, led}, exp_v);
        end
      end
    end
    checks++;
    if (ev_count != 1) begin
      errors++;
      $display("[TB] FAIL midrst_event_count: got %0d expected 1", ev_count);
    end
  endtask

  // Scenario sequence; each scenario leaves state the next one relies on.
  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    switch_n = 4'b1111;
    led_mask = '0;
    led_mode = '0;
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_toggle();
    test_blink();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
